// File: rtl/matrix_uart_printer_pkg.sv
// Shared types and constants for the matrix printer: matrix shape, ASCII codes
// and the printer FSM state encoding.
package project_pkg;

    localparam int MAT_MAX_ROWS = 5;
    localparam int MAT_MAX_COLS = 5;
    localparam int ROW_IDX_W    = 3;
    localparam int COL_IDX_W    = 3;
    localparam int CHAR_BUF_LEN = 6;

    typedef logic signed [7:0] matrix_element_t;

    typedef struct packed {
        logic [ROW_IDX_W-1:0] rows;
        logic [COL_IDX_W-1:0] cols;
        matrix_element_t [MAT_MAX_ROWS-1:0][MAT_MAX_COLS-1:0] data;
    } matrix_t;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_X     = 8'h78;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    typedef logic [2:0] mtx_prn_state_t;
    localparam mtx_prn_state_t PRN_IDLE    = 3'd0;
    localparam mtx_prn_state_t PRN_LOAD    = 3'd1;
    localparam mtx_prn_state_t PRN_SEND    = 3'd2;
    localparam mtx_prn_state_t PRN_WAIT_HI = 3'd3;
    localparam mtx_prn_state_t PRN_WAIT_LO = 3'd4;
    localparam mtx_prn_state_t PRN_DONE    = 3'd5;

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return ASCII_ZERO + {4'b0000, d};
    endfunction

endpackage

// File: rtl/matrix_uart_printer_if.sv
// Request/status and uart_tx byte-strobe signals of the matrix printer.
interface matrix_uart_printer_if;
    import project_pkg::*;

    logic       start;
    matrix_t    matrix;
    logic       busy;
    logic       done;
    logic       tx_en;
    logic [7:0] tx_byte;
    logic       tx_busy;

    modport master (
        input  start, matrix, tx_busy,
        output busy, done, tx_en, tx_byte
    );

    modport slave (
        output start, matrix, tx_busy,
        input  busy, done, tx_en, tx_byte
    );

endinterface

// File: rtl/matrix_uart_printer_dec_digit_split.sv
// Splits a signed 8-bit value into sign, decimal digits and significant digit count.
module dec_digit_split
    import project_pkg::*;
(
    input  matrix_element_t value_i,
    output logic            neg_o,
    output logic [3:0]      hund_o,
    output logic [3:0]      tens_o,
    output logic [3:0]      ones_o,
    output logic [1:0]      ndig_o
);

    logic [7:0] raw;
    logic [7:0] mag;

    // Unsigned 8-bit negate keeps -128 representable as magnitude 128.
    assign raw    = value_i;
    assign neg_o  = raw[7];
    assign mag    = raw[7] ? (~raw + 8'd1) : raw;
    assign hund_o = 4'(mag / 8'd100);
    assign tens_o = 4'((mag / 8'd10) % 8'd10);
    assign ones_o = 4'(mag % 8'd10);
    assign ndig_o = (mag >= 8'd100) ? 2'd3 : (mag >= 8'd10) ? 2'd2 : 2'd1;

endmodule

// File: rtl/matrix_uart_printer.sv
// Prints a latched matrix as signed-decimal ASCII rows onto the uart_tx byte strobe.
// Optional MATRIX_TX_HEADER_EN prefixes the stream with "<rows>x<cols>\r\n".
module matrix_uart_printer
    import project_pkg::*;
#(
    parameter int MAX_ROWS = 5,
    parameter int MAX_COLS = 5
) (
    input logic                   clk,
    input logic                   rst,
    matrix_uart_printer_if.master bus
);

`ifdef MATRIX_TX_HEADER_EN
    localparam logic HDR_EN = 1'b1;
`else
    localparam logic HDR_EN = 1'b0;
`endif

    typedef logic [CHAR_BUF_LEN-1:0][7:0] char_buf_t;

    mtx_prn_state_t state_q, state_d;
    matrix_element_t [MAT_MAX_ROWS-1:0][MAT_MAX_COLS-1:0] data_q, data_d;
    logic [ROW_IDX_W-1:0] rows_q, rows_d, row_q, row_d, rows_clamp;
    logic [COL_IDX_W-1:0] cols_q, cols_d, col_q, col_d, cols_clamp;
    char_buf_t  chars_q, chars_d, elem_chars, hdr_chars;
    logic [2:0] cnt_q, cnt_d, idx_q, idx_d, elem_cnt, pos;
    logic [7:0] tx_byte_q, tx_byte_d;
    logic       fin_q, fin_d, hdr_q, hdr_d;
    logic       last_col, last_row, empty;
    logic       dig_neg;
    logic [3:0] dig_h, dig_t, dig_o;
    logic [1:0] dig_n;

    dec_digit_split u_split (
        .value_i (data_q[row_q][col_q]),
        .neg_o   (dig_neg),
        .hund_o  (dig_h),
        .tens_o  (dig_t),
        .ones_o  (dig_o),
        .ndig_o  (dig_n)
    );

    assign rows_clamp = (bus.matrix.rows > ROW_IDX_W'(MAX_ROWS)) ? ROW_IDX_W'(MAX_ROWS) : bus.matrix.rows;
    assign cols_clamp = (bus.matrix.cols > COL_IDX_W'(MAX_COLS)) ? COL_IDX_W'(MAX_COLS) : bus.matrix.cols;
    assign last_col   = (col_q == cols_q - 1'b1);
    assign last_row   = (row_q == rows_q - 1'b1);
    assign empty      = (rows_q == '0) || (cols_q == '0);

    always_comb begin
        hdr_chars    = '0;
        hdr_chars[0] = ascii_digit({1'b0, rows_q});
        hdr_chars[1] = ASCII_X;
        hdr_chars[2] = ascii_digit({1'b0, cols_q});
        hdr_chars[3] = ASCII_CR;
        hdr_chars[4] = ASCII_LF;
    end

    // Packs the current element and its separator left-aligned into the buffer.
    always_comb begin
        elem_chars = '0;
        pos        = '0;
        if (dig_neg) begin
            elem_chars[pos] = ASCII_MINUS;
            pos = pos + 3'd1;
        end
        if (dig_n == 2'd3) begin
            elem_chars[pos] = ascii_digit(dig_h);
            pos = pos + 3'd1;
        end
        if (dig_n >= 2'd2) begin
            elem_chars[pos] = ascii_digit(dig_t);
            pos = pos + 3'd1;
        end
        elem_chars[pos] = ascii_digit(dig_o);
        pos = pos + 3'd1;
        if (last_col) begin
            elem_chars[pos]        = ASCII_CR;
            elem_chars[pos + 3'd1] = ASCII_LF;
            pos = pos + 3'd2;
        end else begin
            elem_chars[pos] = ASCII_SPACE;
            pos = pos + 3'd1;
        end
        elem_cnt = pos;
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        rows_d    = rows_q;
        cols_d    = cols_q;
        row_d     = row_q;
        col_d     = col_q;
        chars_d   = chars_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        tx_byte_d = tx_byte_q;
        fin_d     = fin_q;
        hdr_d     = hdr_q;
        case (state_q)
            PRN_IDLE, PRN_DONE: begin
                state_d = PRN_IDLE;
                if (bus.start) begin
                    state_d = PRN_LOAD;
                    data_d  = bus.matrix.data;
                    rows_d  = rows_clamp;
                    cols_d  = cols_clamp;
                    row_d   = '0;
                    col_d   = '0;
                    fin_d   = 1'b0;
                    hdr_d   = HDR_EN;
                end
            end
            PRN_LOAD: begin
                if (hdr_q) begin
                    chars_d   = hdr_chars;
                    cnt_d     = 3'd5;
                    idx_d     = 3'd1;
                    tx_byte_d = hdr_chars[0];
                    hdr_d     = 1'b0;
                    state_d   = PRN_SEND;
                end else if (empty) begin
                    state_d = PRN_DONE;
                end else begin
                    chars_d   = elem_chars;
                    cnt_d     = elem_cnt;
                    idx_d     = 3'd1;
                    tx_byte_d = elem_chars[0];
                    fin_d     = last_col && last_row;
                    state_d   = PRN_SEND;
                    if (last_col) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            PRN_SEND:    state_d = PRN_WAIT_HI;
            PRN_WAIT_HI: if (bus.tx_busy) state_d = PRN_WAIT_LO;
            PRN_WAIT_LO: begin
                if (!bus.tx_busy) begin
                    if (idx_q < cnt_q) begin
                        tx_byte_d = chars_q[idx_q];
                        idx_d     = idx_q + 3'd1;
                        state_d   = PRN_SEND;
                    end else if (fin_q) begin
                        state_d = PRN_DONE;
                    end else begin
                        state_d = PRN_LOAD;
                    end
                end
            end
            default: state_d = PRN_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= PRN_IDLE;
            data_q    <= '0;
            rows_q    <= '0;
            cols_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            chars_q   <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            tx_byte_q <= '0;
            fin_q     <= 1'b0;
            hdr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            rows_q    <= rows_d;
            cols_q    <= cols_d;
            row_q     <= row_d;
            col_q     <= col_d;
            chars_q   <= chars_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            tx_byte_q <= tx_byte_d;
            fin_q     <= fin_d;
            hdr_q     <= hdr_d;
        end
    end

    assign bus.tx_en   = (state_q == PRN_SEND);
    assign bus.tx_byte = tx_byte_q;
    assign bus.busy    = (state_q != PRN_IDLE) && (state_q != PRN_DONE);
    assign bus.done    = (state_q == PRN_DONE);

endmodule

// File: tb/tb_matrix_uart_printer.sv
// Self-checking bench for matrix_uart_printer with a cycle-counting uart_tx busy model.
// Honours MATRIX_TX_HEADER_EN when building expected streams.
module tb_matrix_uart_printer;
    import project_pkg::*;

    typedef struct {
        matrix_t mtx;
        int      busyLen;
        int      expRows;
        int      expCols;
        string   expText;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    matrix_uart_printer_if bus();

    matrix_uart_printer #(.MAX_ROWS(5), .MAX_COLS(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         busyLen = 1;
    int         busyCnt = 0;
    int         doneCnt = 0;
    int         violations = 0;
    logic       prevEn = 1'b0;
    logic [7:0] rxBytes[$];
    vec_t       vecs[5];

    // uart_tx stand-in: busy rises on the edge that samples tx_en and stays up busyLen cycles.
    always @(posedge clk) begin
        if (bus.tx_en) busyCnt <= busyLen;
        else if (busyCnt != 0) busyCnt <= busyCnt - 1;
    end
    assign bus.tx_busy = (busyCnt != 0);

    always @(negedge clk) begin
        if (bus.tx_en) begin
            rxBytes.push_back(bus.tx_byte);
            if (bus.tx_busy) violations++;
            if (prevEn) violations++;
        end
        if (bus.done) doneCnt++;
        prevEn = bus.tx_en;
    end

    function automatic string crlf(input string s);
        string o = "";
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == "|") o = $sformatf("%s%c%c", o, 8'h0D, 8'h0A);
            else o = $sformatf("%s%c", o, s[i]);
        end
        return o;
    endfunction

    function automatic string show(input string s);
        string o = "";
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == 8'h0D) o = {o, "<CR>"};
            else if (s[i] == 8'h0A) o = {o, "<LF>"};
            else o = $sformatf("%s%c", o, s[i]);
        end
        return o;
    endfunction

    function automatic string rxText();
        string o = "";
        foreach (rxBytes[i]) o = $sformatf("%s%c", o, rxBytes[i]);
        return o;
    endfunction

    function automatic string hdrText(input int r, input int c);
`ifdef MATRIX_TX_HEADER_EN
        return crlf($sformatf("%0dx%0d|", r, c));
`else
        return (r < 0 || c < 0) ? "?" : "";
`endif
    endfunction

    function automatic matrix_t mkDims(input int r, input int c);
        matrix_t m = '0;
        m.rows = ROW_IDX_W'(r);
        m.cols = COL_IDX_W'(c);
        return m;
    endfunction

    function automatic matrix_t rowSet(input matrix_t m, input int r,
                                       input int a, input int b, input int c, input int d, input int e);
        matrix_t o = m;
        o.data[r][0] = 8'(a);
        o.data[r][1] = 8'(b);
        o.data[r][2] = 8'(c);
        o.data[r][3] = 8'(d);
        o.data[r][4] = 8'(e);
        return o;
    endfunction

    task automatic checkOutput(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic checkText(input string name, input string got, input string exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got \"%s\" (%0d bytes), expected \"%s\" (%0d bytes)",
                     name, show(got), got.len(), show(exp), exp.len());
        end
    endtask

    task automatic applyStimulus(input matrix_t m, input int bl);
        @(negedge clk);
        busyLen    = bl;
        bus.matrix = m;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    task automatic waitDone(input string name, input int maxCycles);
        int n = 0;
        while (doneCnt == 0 && n < maxCycles) begin
            @(posedge clk);
            n++;
        end
        if (doneCnt == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: done not seen within %0d cycles", name, maxCycles);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic waitBytes(input string name, input int count, input int maxCycles);
        int n = 0;
        while (rxBytes.size() < count && n < maxCycles) begin
            @(posedge clk);
            n++;
        end
        if (rxBytes.size() < count) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: got %0d bytes, expected %0d within %0d cycles",
                     name, rxBytes.size(), count, maxCycles);
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{rowSet(rowSet(mkDims(2, 3), 0, 1, -2, 3, 0, 0), 1, 100, -128, 0, 0, 0),
                    10, 2, 3, crlf("1 -2 3|100 -128 0|")};
        vecs[1] = '{mkDims(1, 1), 1, 1, 1, crlf("0|")};
        vecs[2] = '{rowSet(rowSet(mkDims(2, 2), 0, 127, -1, 0, 0, 0), 1, -10, 5, 0, 0, 0),
                    3, 2, 2, crlf("127 -1|-10 5|")};
        vecs[3] = '{rowSet(rowSet(rowSet(rowSet(rowSet(mkDims(7, 1),
                        0, 9, 11, 12, 13, 14), 1, -99, 21, 0, 0, 0), 2, 10, 31, 0, 0, 0),
                        3, -100, 41, 0, 0, 0), 4, 55, 51, 0, 0, 0),
                    2, 5, 1, crlf("9|-99|10|-100|55|")};
        vecs[4] = '{rowSet(mkDims(1, 6), 0, -5, 0, 42, -7, 99), 1, 1, 5, crlf("-5 0 42 -7 99|")};
        foreach (vecs[i]) vecs[i].expText = {hdrText(vecs[i].expRows, vecs[i].expCols), vecs[i].expText};

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.matrix = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset tx_en", int'(bus.tx_en), 0);
        checkOutput("reset tx_byte", int'(bus.tx_byte), 0);
        checkOutput("reset busy", int'(bus.busy), 0);
        checkOutput("reset done", int'(bus.done), 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            rxBytes.delete();
            doneCnt = 0;
            applyStimulus(vecs[i].mtx, vecs[i].busyLen);
            waitDone($sformatf("vec%0d", i), 3000);
            checkText($sformatf("vec%0d stream", i), rxText(), vecs[i].expText);
            checkOutput($sformatf("vec%0d done pulses", i), doneCnt, 1);
        end

        // Start latency: busy one cycle after the accepted start, first strobe one cycle later.
        rxBytes.delete();
        doneCnt = 0;
        applyStimulus(vecs[1].mtx, 1);
        checkOutput("latency busy at N+1", int'(bus.busy), 1);
        checkOutput("latency tx_en at N+1", int'(bus.tx_en), 0);
        @(negedge clk);
        checkOutput("latency tx_en at N+2", int'(bus.tx_en), 1);
`ifdef MATRIX_TX_HEADER_EN
        checkOutput("latency first byte", int'(bus.tx_byte), 8'h31);
`else
        checkOutput("latency first byte", int'(bus.tx_byte), 8'h30);
`endif
        waitDone("latency", 500);
        checkText("latency stream", rxText(), vecs[1].expText);

        rxBytes.delete();
        doneCnt = 0;
        applyStimulus(mkDims(0, 3), 1);
        checkOutput("empty busy at N+1", int'(bus.busy), 1);
`ifdef MATRIX_TX_HEADER_EN
        waitDone("empty", 500);
        checkText("empty header stream", rxText(), crlf("0x3|"));
`else
        checkOutput("empty done at N+1", int'(bus.done), 0);
        @(negedge clk);
        checkOutput("empty done at N+2", int'(bus.done), 1);
        checkOutput("empty busy at N+2", int'(bus.busy), 0);
        repeat (5) @(negedge clk);
        checkOutput("empty byte count", rxBytes.size(), 0);
`endif
        checkOutput("empty done pulses", doneCnt, 1);

        rxBytes.delete();
        doneCnt = 0;
        applyStimulus(vecs[0].mtx, 10);
        waitBytes("midstream start", 5, 2000);
        applyStimulus(vecs[2].mtx, 10);
        waitDone("midstream", 3000);
        repeat (100) @(negedge clk);
        checkText("midstream stream", rxText(), vecs[0].expText);
        checkOutput("midstream done pulses", doneCnt, 1);

        rxBytes.delete();
        doneCnt = 0;
        applyStimulus(vecs[0].mtx, 10);
        waitBytes("reset midstream", 5, 2000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midreset busy", int'(bus.busy), 0);
        checkOutput("midreset tx_en", int'(bus.tx_en), 0);
        checkOutput("midreset tx_byte", int'(bus.tx_byte), 0);
        checkOutput("midreset done", int'(bus.done), 0);
        rst = 1'b0;
        for (int n = 0; n < 50 && bus.tx_busy; n++) @(negedge clk);
        rxBytes.delete();
        doneCnt = 0;
        applyStimulus(vecs[0].mtx, 10);
        waitDone("after reset", 3000);
        checkText("after reset stream", rxText(), vecs[0].expText);
        checkOutput("after reset done pulses", doneCnt, 1);

        checkOutput("tx_en protocol violations", violations, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
